// File: rtl/uart_dte_rx.sv
// UART receiver (DTE side): 8N1 deserializer, small receive FIFO and RTS flow control.
// Define UART_DTE_RX_PARITY_EN to expect an even-parity bit between bit 7 and the stop bit.
module uart_dte_rx #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rxd,
  output logic             rts,
  input  logic [DIV_W-1:0] divisor,
  output logic [7:0]       dat,
  output logic             dat_valid,
  input  logic             dat_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_DTE_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StWaitIdle
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rxs;
  logic [DIV_W-1:0] div_q, timer_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic             tick, par_bad;
  logic             start_det, reload, shift_en, par_chk, push, fe_set, pe_set;

  // Synchronizer flops reset to the idle (mark) level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q <= 1'b1;
      rxs       <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rxs       <= rx_meta_q;
    end
  end

  assign tick = (timer_q == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!rxs) state_d = StStart;
      StStart: if (tick) state_d = rxs ? StIdle : StData;
      StData: begin
        if (tick && idx_q == 3'd7) begin
`ifdef UART_DTE_RX_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
`ifdef UART_DTE_RX_PARITY_EN
      StParity: if (tick) state_d = StStop;
`endif
      StStop:     if (tick) state_d = rxs ? StIdle : StWaitIdle;
      StWaitIdle: if (rxs) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    start_det = 1'b0;
    reload    = 1'b0;
    shift_en  = 1'b0;
    par_chk   = 1'b0;
    push      = 1'b0;
    fe_set    = 1'b0;
    pe_set    = 1'b0;
    unique case (state_q)
      StIdle:  start_det = !rxs;
      StStart: reload = tick;
      StData: begin
        reload   = tick;
        shift_en = tick;
      end
`ifdef UART_DTE_RX_PARITY_EN
      StParity: begin
        reload  = tick;
        par_chk = tick;
      end
`endif
      StStop: begin
        if (tick) begin
          if (!rxs)        fe_set = 1'b1;
          else if (par_bad) pe_set = 1'b1;
          else             push   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Bit timer: half a bit to the start-bit centre, then one full bit per sample.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q   <= '0;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      if (start_det) begin
        div_q   <= divisor;
        timer_q <= (divisor >> 1) - DIV_W'(1);
        idx_q   <= '0;
      end else if (reload) begin
        timer_q <= div_q - DIV_W'(1);
      end else if (!tick) begin
        timer_q <= timer_q - DIV_W'(1);
      end
      if (shift_en) begin
        shift_q[idx_q] <= rxs;
        idx_q          <= idx_q + 3'd1;
      end
    end
  end

`ifdef UART_DTE_RX_PARITY_EN
  logic par_bad_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         par_bad_q <= 1'b0;
    else if (start_det) par_bad_q <= 1'b0;
    else if (par_chk)   par_bad_q <= (rxs != ^shift_q);
  end
  assign par_bad = par_bad_q;
`else
  assign par_bad = 1'b0;
`endif

  // Receive FIFO
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pop, full, wr_en;

  assign dat_valid = (cnt_q != '0);
  assign dat       = mem_q[rd_ptr_q];
  assign pop       = dat_valid && dat_ready;
  assign full      = (cnt_q == CntW'(FIFO_DEPTH));
  assign wr_en     = push && (!full || pop);

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en && !pop)      cnt_d = cnt_q + CntW'(1);
    else if (!wr_en && pop) cnt_d = cnt_q - CntW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rts        <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q      <= cnt_d;
      // One entry stays free for a frame already on the wire when rts drops.
      rts        <= (cnt_d <= CntW'(FIFO_DEPTH - 2));
      frame_err  <= fe_set;
      overrun    <= push && full && !pop;
      parity_err <= pe_set;
    end
  end

endmodule

// File: tb/tb_uart_dte_rx.sv
// Directed bench for uart_dte_rx: a queue-level model predicts FIFO contents, rts and
// error pulses from frame timing; a negedge process compares every cycle.
module tb_uart_dte_rx;

  localparam int unsigned DEPTH = 4;
  localparam int DIV = 16;
`ifdef UART_DTE_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rxd = 1'b1;
  logic        rts;
  logic [15:0] divisor = 16'(DIV);
  logic [7:0]  dat;
  logic        dat_valid;
  logic        dat_ready = 1'b0;
  logic        frame_err, overrun, parity_err;

  uart_dte_rx #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
    .clk(clk), .rstn(rstn), .rxd(rxd), .rts(rts), .divisor(divisor),
    .dat(dat), .dat_valid(dat_valid), .dat_ready(dat_ready),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_n;
    int         kind;   // 0 good byte, 1 framing error, 2 parity error
    logic [7:0] b;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] mq[$];
  logic [7:0] got[$];
  int         cyc = 0;
  int         last_e = 0;
  logic       rts_e = 1'b0, fe_e = 1'b0, ov_e = 1'b0, pe_e = 1'b0;
  int         total = 0, bad = 0;
  int         fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: at each edge apply the frame outcome due then, and the consumer's pop.
  always @(posedge clk) begin
    cyc++;
    if (!rstn) begin
      mq.delete();
      evq.delete();
      rts_e = 1'b0; fe_e = 1'b0; ov_e = 1'b0; pe_e = 1'b0;
    end else begin : model
      bit   pop, psh;
      ev_t  ev;
      pop = (mq.size() != 0) && dat_ready;
      psh = 1'b0;
      fe_e = 1'b0; ov_e = 1'b0; pe_e = 1'b0;
      ev = '{0, 0, 8'h00};
      if (evq.size() != 0 && evq[0].edge_n == cyc) begin
        ev = evq.pop_front();
        if (ev.kind == 0)      psh  = 1'b1;
        else if (ev.kind == 1) fe_e = 1'b1;
        else                   pe_e = 1'b1;
      end
      if (pop) void'(mq.pop_front());
      if (psh) begin
        if (mq.size() < DEPTH) mq.push_back(ev.b);
        else                   ov_e = 1'b1;
      end
      rts_e = (mq.size() <= DEPTH - 2);
    end
  end

  always @(posedge clk)
    if (rstn && dat_valid && dat_ready) got.push_back(dat);

  always @(negedge clk) begin
    fe_cnt += int'(frame_err);
    ov_cnt += int'(overrun);
    pe_cnt += int'(parity_err);
    if (!rstn) begin
      check("rst_rts", rts, 0);
      check("rst_valid", dat_valid, 0);
      check("rst_dat", dat, 0);
      check("rst_flags", {frame_err, overrun, parity_err}, 0);
    end else begin
      check("rts", rts, rts_e);
      check("dat_valid", dat_valid, mq.size() != 0);
      if (mq.size() != 0) check("dat", dat, mq[0]);
      check("frame_err", frame_err, fe_e);
      check("overrun", overrun, ov_e);
      check("parity_err", parity_err, pe_e);
    end
  end

  // Drive one frame; start bit begins right after edge k, stop sample lands on edge
  // k + 3 (sync + detect) + DIV/2 + NB*DIV. A bad stop leaves rxd low for the caller.
  task automatic send(input logic [7:0] b, input bit bad_stop, input bit bad_par);
    int k;
    @(posedge clk);
    #1;
    k = cyc;
    last_e = k + 3 + DIV / 2 + NB * DIV;
    evq.push_back('{last_e, bad_stop ? 1 : (bad_par ? 2 : 0), b});
    rxd = 1'b0;
    repeat (DIV) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rxd = b[i];
      repeat (DIV) @(posedge clk);
    end
`ifdef UART_DTE_RX_PARITY_EN
    #1 rxd = (^b) ^ bad_par;
    repeat (DIV) @(posedge clk);
`endif
    #1 rxd = !bad_stop;
    repeat (DIV) @(posedge clk);
    #1 if (!bad_stop) rxd = 1'b1;
  endtask

  task automatic drain();
    @(posedge clk);
    #1 dat_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1 dat_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, ov0, pe0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1 check("rts_after_reset", rts, 1);

    // Single byte
    fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    send(8'hA5, 0, 0);
    check("t1_dat", dat, 8'hA5);
    check("t1_valid", dat_valid, 1);
    check("t1_no_flags", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0), 0);
    drain();

    // Glitch shorter than half a bit
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (5) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (30) @(posedge clk);
    #1 check("t2_valid", dat_valid, 0);
    check("t2_no_flags", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0), 0);

    // Framing error followed by break, then a good byte
    send(8'h3C, 1, 0);
    repeat (40) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (5) @(posedge clk);
    check("t3_fe_once", fe_cnt - fe0, 1);
    check("t3_no_byte", dat_valid, 0);
    send(8'h11, 0, 0);
    check("t3_dat", dat, 8'h11);
    drain();

    // Flow control and overrun
    got.delete();
    ov0 = ov_cnt;
    send(8'h01, 0, 0);
    send(8'h02, 0, 0);
    check("t4_rts_2", rts, 1);
    send(8'h03, 0, 0);
    check("t4_rts_3", rts, 0);
    send(8'h04, 0, 0);
    send(8'h05, 0, 0);
    check("t4_overrun", ov_cnt - ov0, 1);
    check("t4_head", dat, 8'h01);
    drain();
    check("t4_count", got.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) check("t4_order", got[i], i + 1);
    check("t4_rts_back", rts, 1);

    // Push and pop on the same edge while full
    send(8'h21, 0, 0);
    send(8'h22, 0, 0);
    send(8'h23, 0, 0);
    send(8'h24, 0, 0);
    got.delete();
    ov0 = ov_cnt;
    last_e = 0;
    fork
      send(8'h25, 0, 0);
      begin
        wait (last_e != 0);
        wait (cyc == last_e - 1);
        #1 dat_ready = 1'b1;
        @(posedge clk);
        #1 dat_ready = 1'b0;
      end
    join
    check("t5_no_overrun", ov_cnt - ov0, 0);
    check("t5_rts", rts, 0);
    check("t5_head", dat, 8'h22);
    check("t5_popped", got.size(), 1);
    drain();
    check("t5_count", got.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < got.size()) check("t5_order", got[i], 8'h21 + i);

    // Reset mid-frame with a byte buffered
    send(8'h66, 0, 0);
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (50) @(posedge clk);
    #1 rstn = 1'b0;
    rxd = 1'b1;
    @(negedge clk);
    check("t6_empty", dat_valid, 0);
    check("t6_rts", rts, 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1 check("t6_rts_rise", rts, 1);
    send(8'h5A, 0, 0);
    check("t6_dat", dat, 8'h5A);
    drain();

`ifdef UART_DTE_RX_PARITY_EN
    pe0 = pe_cnt;
    send(8'h07, 0, 1);
    repeat (4) @(posedge clk);
    check("t6_parity_err", pe_cnt - pe0, 1);
    check("t6_parity_drop", dat_valid, 0);
    send(8'h07, 0, 0);
    check("t6_parity_ok", dat, 8'h07);
    drain();
`endif

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
